// File: rtl/serial_link_pkg.sv
// Constants and state encoding shared by both ends of the 50 kbaud serial link.
package serial_link_pkg;

  localparam logic [24:0] BIT_DIVISOR = 25'd400;
  localparam logic [3:0]  DATA_BITS   = 4'd8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs; idles at 1 so a released line reads as idle.
// Latency two clocks; no flow control.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_sig,
  output logic [WIDTH-1:0] synced
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta   <= '1;
      synced <= '1;
    end else begin
      meta   <= async_sig;
      synced <= meta;
    end
  end

endmodule

// File: rtl/serial_rx_50k.sv
// 50 kbaud receiver, start + 8 data (LSB first) + stop, sampled mid-bit; SERIAL_RX_PARITY_EN adds an even-parity bit.
// Start edge to data_valid: 3 + DIVISOR/2 + (DATA_BITS+1)*DIVISOR cycles (+DIVISOR with parity); no backpressure.
module serial_rx_50k #(
  parameter logic [24:0] DIVISOR   = serial_link_pkg::BIT_DIVISOR,
  parameter logic [3:0]  DATA_BITS = serial_link_pkg::DATA_BITS
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
`ifdef SERIAL_RX_PARITY_EN
  ,
  output logic       parity_error
`endif
);

  import serial_link_pkg::*;

  localparam logic [24:0] HALF_LAST = (DIVISOR >> 1) - 25'd1;
  localparam logic [24:0] BIT_LAST  = DIVISOR - 25'd1;
  localparam logic [3:0]  IDX_LAST  = DATA_BITS - 4'd1;

  rx_state_t   state;
  logic [24:0] cnt;
  logic [3:0]  bit_idx;
  logic [7:0]  shreg;
  logic        line;
  logic        line_d;
  logic        fall;
`ifdef SERIAL_RX_PARITY_EN
  logic        par_bit;
`endif

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk       (clock_in),
    .reset_n   (reset_n),
    .async_sig (serial_in),
    .synced    (line)
  );

  assign fall = line_d & ~line;

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      line_d      <= 1'b1;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      line_d      <= line;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        // Half a bit in, the start bit must still be low or it was a glitch.
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!line) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 25'd1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {line, shreg[7:1]};
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
`ifdef SERIAL_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            cnt <= cnt + 25'd1;
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bit <= line;
            state   <= STOP;
          end else begin
            cnt <= cnt + 25'd1;
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (line) begin
`ifdef SERIAL_RX_PARITY_EN
              if ((^shreg) == par_bit) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
              end else begin
                parity_error <= 1'b1;
              end
`else
              data_out   <= shreg;
              data_valid <= 1'b1;
`endif
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_error <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            cnt <= cnt + 25'd1;
          end
        end
        // A held-low line stays here so it reports a single error.
        BREAK: begin
          if (line) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
